arbiter_merge_rr: RTL and testbench
===================================

# arbiter_merge_rr

Parametrised, clocked N-input round-robin arbiter-merge with a buffered output, generalising the fixed 14-input arbiter tree to any channel count. Each cycle it grants at most one requesting input and tags the beat with its source index. It writes the beat into a small output FIFO. It sits where many producers (PE outputs, router ports) converge onto one shared channel. Optional packet locking keeps multi-beat packets contiguous.

## Interface
- NUM_IN, 14: number of input channels, ≥2.
- WIDTH, 14: payload width per channel.
- DEPTH, 2: output FIFO entries; power of 2, ≥2.
- IDW (localparam), $clog2(NUM_IN): source-index width.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-input request.
- in_ready  out  NUM_IN  per-input grant/accept.
- in_data  in  NUM_IN*WIDTH  payload; input i at bits [i*WIDTH +: WIDTH].
- in_last  in  NUM_IN  end-of-packet flag per input.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- out_data  out  WIDTH  head payload.
- out_src  out  IDW  head source index.
- out_last  out  1  head end-of-packet flag.

## Operation
- Handshake: a beat transfers on a cycle where valid && ready are both high, on input or output side.
- State: rr_ptr (IDW bits), FIFO storage {data,src,last} × DEPTH, wr_ptr, rd_ptr, count ($clog2(DEPTH)+1 bits).
- full = (count == DEPTH). Pushes are blocked when full, even if a pop occurs in the same cycle.
- Winner = first i with in_valid[i], scanning cyclically from rr_ptr through NUM_IN−1, wrapping to 0.
- in_ready[i] = !full && (i == winner). It is one-hot or zero and combinational from in_valid, rr_ptr and count. Sources must not make in_valid depend on in_ready.
- On accept from input w: push {in_data[w], w, in_last[w]}; rr_ptr ← (w == NUM_IN−1) ? 0 : w+1.
- No request, or full: rr_ptr is held and nothing is pushed.
- Pop: out_valid && out_ready advances rd_ptr.
- Simultaneous push and pop (not full): count unchanged.
- Pointers wrap modulo DEPTH.
- Each input sees at most NUM_IN−1 competing grants between its own grants. There is no starvation.
- Dropping valid before it is granted is legal and discards nothing.

## Timing
- Reset values: in_ready = 0, out_valid = 0, out_data = 0, out_src = 0, out_last = 0, rr_ptr = 0, count = 0, lock cleared.
- Reset mid-operation discards all buffered beats. Outputs return to the reset values on the cycle after rst is sampled high.
- Latency: a beat accepted at edge t is visible on out_* from t+1 (out_valid = 1).
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- When DEPTH beats are buffered and out_ready = 0, all in_ready = 0 until a pop lowers count.
- out_* are driven from FIFO registers or the memory read mux, with no combinational path from inputs.

## Configuration
- Macro: ARB_MERGE_PKT_LOCK_EN.
- Defined: accepting a beat with in_last = 0 from input w sets lock to w. While locked, only input w may win, and rr_ptr is not updated. Accepting a beat from w with in_last = 1 clears the lock and sets rr_ptr ← w+1 (wrapping).
- Defined: when locked and in_valid[w] = 0, no grant is made, even if other inputs request.
- Undefined: in_last is carried to out_last only. Arbitration is per beat and no lock state exists.

## Structure
- Shared package arb_pkg: IDW computation function, the FIFO entry struct typedef (payload, source index, last flag), and the reset constants.
- One sub-module, arb_out_fifo: parametrised synchronous FIFO of entry structs with push, pop, full, empty and count. The round-robin picker stays inline.

## Test plan
- Reset: hold rst high for 3 cycles with all in_valid = 1 → in_ready = 0, out_valid = 0, out_data = 0 throughout. After release, the first grant goes to input 0.
- All 14 valid, out_ready = 1, in_data[i] = i+0x100 → out_src sequence 0,1,…,13,0 at 1 beat/cycle, with matching data.
- Only inputs 3 and 9 valid → out_src alternates 3,9,3,9.
- out_ready = 0, DEPTH = 2 → two beats accepted, then in_ready = 0. Raising out_ready then resumes with no loss or duplication.
- Lock defined: input 5 sends 3 beats (last = 0,0,1) while input 6 is valid → out_src = 5,5,5,6. Lock undefined → out_src = 5,6,5,6,5.
- rst asserted while the FIFO holds 2 beats → out_valid = 0 the next cycle, and no stale beat appears afterwards.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter-merge and its output FIFO.
package arb_pkg;

   localparam int unsigned ARB_DEF_NUM_IN = 14;
   localparam int unsigned ARB_DEF_WIDTH  = 14;
   localparam int unsigned ARB_DEF_IDW    = $clog2(ARB_DEF_NUM_IN);

   // Reset values for the arbitration pointer and FIFO occupancy.
   localparam int unsigned ARB_RST_RR_PTR = 0;
   localparam int unsigned ARB_RST_COUNT  = 0;

   function automatic int unsigned arb_idw(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [ARB_DEF_WIDTH-1:0] data;
      logic [ARB_DEF_IDW-1:0]   src;
      logic                     last;
   } arb_entry_t;

endpackage

// File: rtl/arb_out_fifo.sv
// Synchronous FIFO of arbiter entries; read data comes straight from the storage mux.
module arb_out_fifo
   import arb_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   parameter  type         T     = arb_entry_t,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  T              i_wdata,
   input  logic          i_pop,
   output T              o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage is cleared on reset so the head fields read as zero while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= CW'(ARB_RST_COUNT);
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbiter_merge_rr.sv
// N-input round-robin arbiter-merge into a tagged output FIFO.
// Packet locking (contiguous multi-beat packets) is enabled by defining ARB_MERGE_PKT_LOCK_EN.
module arbiter_merge_rr
   import arb_pkg::*;
#(
   parameter  int unsigned NUM_IN = 14,
   parameter  int unsigned WIDTH  = 14,
   parameter  int unsigned DEPTH  = 2,
   localparam int unsigned IDW    = arb_idw(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [IDW-1:0]          out_src,
   output logic                    out_last
);

   localparam int unsigned SW = IDW + 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [IDW-1:0]   src;
      logic             last;
   } entry_t;

   logic [IDW-1:0] r_rr_ptr;
`ifdef ARB_MERGE_PKT_LOCK_EN
   logic           r_locked;
   logic [IDW-1:0] r_lock_id;
`endif

   logic [SW-1:0]  w_sum;
   logic           w_found;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_win_inc;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic [CW-1:0]  w_count;
   entry_t         w_wdata;
   entry_t         w_rdata;

   // Cyclic scan from r_rr_ptr; the sum never exceeds 2*NUM_IN-2, so one subtract wraps it.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         w_sum = {1'b0, r_rr_ptr} + SW'(k);
         if (w_sum >= SW'(NUM_IN)) begin
            w_sum = w_sum - SW'(NUM_IN);
         end
         if (!w_found && in_valid[w_sum[IDW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[IDW-1:0];
         end
      end
`ifdef ARB_MERGE_PKT_LOCK_EN
      if (r_locked) begin
         w_found = in_valid[r_lock_id];
         w_win   = r_lock_id;
      end
`endif
   end

   assign w_push    = w_found && !w_full && !rst;
   assign w_pop     = out_valid && out_ready;
   assign w_win_inc = (w_win == IDW'(NUM_IN - 1)) ? '0 : w_win + 1'b1;

   always_comb begin
      in_ready = '0;
      if (w_push) begin
         in_ready[w_win] = 1'b1;
      end
   end

   always_comb begin
      w_wdata      = '0;
      w_wdata.data = in_data[w_win*WIDTH +: WIDTH];
      w_wdata.src  = w_win;
      w_wdata.last = in_last[w_win];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr  <= IDW'(ARB_RST_RR_PTR);
`ifdef ARB_MERGE_PKT_LOCK_EN
         r_locked  <= 1'b0;
         r_lock_id <= '0;
`endif
      end else if (w_push) begin
`ifdef ARB_MERGE_PKT_LOCK_EN
         // The pointer only moves at packet end, so a locked packet never skips fairness.
         if (in_last[w_win]) begin
            r_locked <= 1'b0;
            r_rr_ptr <= w_win_inc;
         end else begin
            r_locked  <= 1'b1;
            r_lock_id <= w_win;
         end
`else
         r_rr_ptr <= w_win_inc;
`endif
      end
   end

   arb_out_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign out_valid = !w_empty;
   assign out_data  = w_rdata.data;
   assign out_src   = w_rdata.src;
   assign out_last  = w_rdata.last;

   a_fifo_flags: assert property (@(posedge clk) disable iff (rst)
      (w_empty == (w_count == '0)) && (w_full == (w_count == CW'(DEPTH))));

endmodule

// File: tb/tb_arbiter_merge_rr.sv
// Scenario bench for arbiter_merge_rr: expected beats are queued at stimulus time and popped on output.
module tb_arbiter_merge_rr;

   localparam int unsigned NUM_IN = 14;
   localparam int unsigned WIDTH  = 14;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned IDW    = 4;
   localparam int unsigned EW     = IDW + WIDTH + 1;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_IN-1:0]       in_valid = '0;
   logic [NUM_IN-1:0]       in_ready;
   logic [NUM_IN*WIDTH-1:0] in_data = '0;
   logic [NUM_IN-1:0]       in_last = '1;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [WIDTH-1:0]        out_data;
   logic [IDW-1:0]          out_src;
   logic                    out_last;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [EW-1:0] sb_q[$];
   logic [EW-1:0] exp_e;
   logic [EW-1:0] got_e;

   arbiter_merge_rr #(
      .NUM_IN (NUM_IN),
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_default_data();
      for (int i = 0; i < NUM_IN; i++) begin
         in_data[i*WIDTH +: WIDTH] = WIDTH'(i + 'h100);
      end
   endtask

   task automatic push_exp(input int src, input int data, input logic last);
      sb_q.push_back({IDW'(src), WIDTH'(data), last});
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = '0;
      in_last   = '1;
      out_ready = 1'b0;
      set_default_data();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = '1;
      in_last   = '1;
      out_ready = 1'b0;
      set_default_data();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== '0) begin
            n_fail++; $display("FAIL reset_in_ready cyc%0d: got %h want 0", c, in_ready);
         end
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid);
         end
         n_cmp++;
         if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_out_data cyc%0d: got %h want 0", c, out_data);
         end
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      sb_q.delete();
      push_exp(0, 'h100, 1'b1);
      #1;
      n_cmp++;
      if (in_ready !== NUM_IN'(1)) begin
         n_fail++; $display("FAIL reset_first_grant: got %h want %h", in_ready, NUM_IN'(1));
      end
      @(negedge clk);
      in_valid = '0;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL reset_first_beat_valid: got %b want 1", out_valid);
      end else begin
         exp_e = sb_q.pop_front();
         got_e = {out_src, out_data, out_last};
         n_cmp++;
         if (got_e !== exp_e) begin
            n_fail++; $display("FAIL reset_first_beat: got %h want %h", got_e, exp_e);
         end
      end
   endtask

   task automatic test_all_valid();
      bit seen;
      do_reset();
      in_valid  = '1;
      in_last   = '1;
      out_ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         push_exp(k % NUM_IN, 'h100 + (k % NUM_IN), 1'b1);
      end
      seen = 1'b0;
      for (int c = 0; c < 40 && sb_q.size() != 0; c++) begin
         if (seen || out_valid) begin
            seen = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1) begin
               n_fail++; $display("FAIL all_valid_throughput cyc%0d: got out_valid %b want 1", c, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            exp_e = sb_q.pop_front();
            got_e = {out_src, out_data, out_last};
            n_cmp++;
            if (got_e !== exp_e) begin
               n_fail++; $display("FAIL all_valid_beat: got %h want %h", got_e, exp_e);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL all_valid_timeout: got %0d outstanding want 0", sb_q.size());
      end
      in_valid = '0;
   endtask

   task automatic test_two_inputs();
      do_reset();
      in_valid  = NUM_IN'((1 << 3) | (1 << 9));
      out_ready = 1'b1;
      push_exp(3, 'h103, 1'b1);
      push_exp(9, 'h109, 1'b1);
      push_exp(3, 'h103, 1'b1);
      push_exp(9, 'h109, 1'b1);
      for (int c = 0; c < 30 && sb_q.size() != 0; c++) begin
         if (out_valid && out_ready) begin
            exp_e = sb_q.pop_front();
            got_e = {out_src, out_data, out_last};
            n_cmp++;
            if (got_e !== exp_e) begin
               n_fail++; $display("FAIL two_inputs_beat: got %h want %h", got_e, exp_e);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL two_inputs_timeout: got %0d outstanding want 0", sb_q.size());
      end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid  = '1;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push_exp(k, 'h100 + k, 1'b1);
      end
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (in_ready !== '0) begin
            n_fail++; $display("FAIL full_in_ready cyc%0d: got %h want 0", c, in_ready);
         end
         n_cmp++;
         if ({out_valid, out_src} !== {1'b1, IDW'(0)}) begin
            n_fail++; $display("FAIL full_head cyc%0d: got v=%b src=%0d want v=1 src=0", c, out_valid, out_src);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 30 && sb_q.size() != 0; c++) begin
         if (out_valid && out_ready) begin
            exp_e = sb_q.pop_front();
            got_e = {out_src, out_data, out_last};
            n_cmp++;
            if (got_e !== exp_e) begin
               n_fail++; $display("FAIL backpressure_beat: got %h want %h", got_e, exp_e);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL backpressure_timeout: got %0d outstanding want 0", sb_q.size());
      end
      in_valid = '0;
   endtask

   task automatic test_lock();
      int   k5;
      logic acc5;
      do_reset();
      k5 = 0;
      in_data[5*WIDTH +: WIDTH] = WIDTH'('h500);
      in_data[6*WIDTH +: WIDTH] = WIDTH'('h600);
      in_last[5] = 1'b0;
      in_last[6] = 1'b1;
      in_valid   = NUM_IN'((1 << 5) | (1 << 6));
      out_ready  = 1'b1;
`ifdef ARB_MERGE_PKT_LOCK_EN
      push_exp(5, 'h500, 1'b0);
      push_exp(5, 'h501, 1'b0);
      push_exp(5, 'h502, 1'b1);
      push_exp(6, 'h600, 1'b1);
`else
      push_exp(5, 'h500, 1'b0);
      push_exp(6, 'h600, 1'b1);
      push_exp(5, 'h501, 1'b0);
      push_exp(6, 'h600, 1'b1);
      push_exp(5, 'h502, 1'b1);
`endif
      for (int c = 0; c < 30 && sb_q.size() != 0; c++) begin
         if (out_valid && out_ready) begin
            exp_e = sb_q.pop_front();
            got_e = {out_src, out_data, out_last};
            n_cmp++;
            if (got_e !== exp_e) begin
               n_fail++; $display("FAIL lock_beat: got %h want %h", got_e, exp_e);
            end
         end
         #1;
         acc5 = in_valid[5] && in_ready[5];
         @(negedge clk);
         if (acc5) begin
            k5++;
            if (k5 == 3) begin
               in_valid[5] = 1'b0;
            end else begin
               in_data[5*WIDTH +: WIDTH] = WIDTH'('h500 + k5);
               in_last[5] = (k5 == 2);
            end
         end
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL lock_timeout: got %0d outstanding want 0", sb_q.size());
      end
      in_valid = '0;
      in_last  = '1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid  = '1;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL midreset_prefill: got out_valid %b want 1", out_valid);
      end
      rst      = 1'b1;
      in_valid = '0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_src, out_data, out_last} !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: got v=%b src=%0d data=%h last=%b want all 0",
                            out_valid, out_src, out_data, out_last);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = NUM_IN'(1 << 7);
      push_exp(7, 'h107, 1'b1);
      #1;
      n_cmp++;
      if (in_ready !== NUM_IN'(1 << 7)) begin
         n_fail++; $display("FAIL midreset_grant: got %h want %h", in_ready, NUM_IN'(1 << 7));
      end
      @(negedge clk);
      in_valid = '0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_fail++; $display("FAIL midreset_stale: got beat src=%0d data=%h want none", out_src, out_data);
            end else begin
               exp_e = sb_q.pop_front();
               got_e = {out_src, out_data, out_last};
               if (got_e !== exp_e) begin
                  n_fail++; $display("FAIL midreset_beat: got %h want %h", got_e, exp_e);
               end
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL midreset_timeout: got %0d outstanding want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_all_valid();
      test_two_inputs();
      test_backpressure();
      test_lock();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
